// File: rtl/sum_com_pkg.sv
// Shared constants and a reference-sum helper for the sum_com adder family.
package sum_com_pkg;

  localparam int SUM_COM_DEFAULT_WIDTH = 4;

  // Zero-extended unsigned sum; callers slice out WIDTH+1 bits.
  function automatic logic [32:0] sum_com_ref(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sum_com_fa.sv
// One-bit full adder cell used as a link in the ripple-carry chain.
module sum_com_fa
  import sum_com_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  always_comb begin
    p    = a ^ b;
    s    = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/sum_com4.sv
// Registered unsigned ripple-carry adder: C = {carry, sum} one clock after a valid A/B.
module sum_com4
  import sum_com_pkg::*;
#(
  parameter int WIDTH = SUM_COM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c_d, c_q;
  logic             vld_d, vld_q;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      sum_com_fa u_fa (
        .a    (A[gi]),
        .b    (B[gi]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Result register only loads on valid input; otherwise it holds the last sum.
  always_comb begin
    c_d   = c_q;
    vld_d = in_valid;
    if (in_valid) begin
      c_d = {carry[WIDTH], sum};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign C         = c_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_sum_com4.sv
// Self-checking bench for sum_com4: directed table, gating/reset sequences, sweep and random traffic.
module tb_sum_com4;
  import sum_com_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A, B;
  logic [4:0] C;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_c;
  logic       exp_v;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] c;
  } vec_t;

  vec_t tbl[8];

  sum_com4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_c(input string name, input logic [4:0] want);
    checks++;
    if (C !== want) begin
      errors++;
      $display("FAIL %s: C got %b want %b", name, C, want);
    end
  endtask

  task automatic check_v(input string name, input logic want);
    checks++;
    if (out_valid !== want) begin
      errors++;
      $display("FAIL %s: out_valid got %b want %b", name, out_valid, want);
    end
  endtask

  // Drive one cycle and advance the behavioural model: register of last valid sum.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v, input string name);
    A = a;
    B = b;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) exp_c = 5'(a) + 5'(b);
    exp_v = v;
    check_c(name, exp_c);
    check_v(name, exp_v);
    $display("%s: A=%b B=%b iv=%b -> C=%b ov=%b", name, a, b, v, C, out_valid);
  endtask

  initial begin
    logic [32:0] r;

    tbl[0] = '{4'b0100, 4'b1111, 5'b10011};
    tbl[1] = '{4'b0000, 4'b0101, 5'b00101};
    tbl[2] = '{4'b0101, 4'b0101, 5'b01010};
    tbl[3] = '{4'b0001, 4'b0101, 5'b00110};
    tbl[4] = '{4'b1111, 4'b1111, 5'b11110};
    tbl[5] = '{4'b0000, 4'b0000, 5'b00000};
    tbl[6] = '{4'b1111, 4'b0001, 5'b10000};
    tbl[7] = '{4'b1010, 4'b0010, 5'b01100};

    exp_c    = '0;
    exp_v    = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 4'b1010;
    B        = 4'b0010;

    // Reset held through edges with valid input present.
    #2;
    check_c("reset_async", 5'b0);
    check_v("reset_async", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_c("reset_hold", 5'b0);
    check_v("reset_hold", 1'b0);
    $display("reset: C=%b ov=%b", C, out_valid);
    #3 rst = 1'b0;
    step(4'b1010, 4'b0010, 1'b1, "post_reset");
    check_c("post_reset_12", 5'b01100);

    // Directed table; each result must be visible exactly one edge later.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].a, tbl[i].b, 1'b1, "table");
      check_c("table_const", tbl[i].c);
    end

    // Valid gating: result holds while operands change.
    step(4'b1010, 4'b0010, 1'b1, "gate_load");
    step(4'b0100, 4'b1111, 1'b0, "gate_hold");
    check_c("gate_hold_const", 5'b01100);
    step(4'b0100, 4'b1111, 1'b1, "gate_reload");
    check_c("gate_reload_const", 5'b10011);

    // Mid-stream reset pulsed between edges on the third vector.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        A = tbl[i].a;
        B = tbl[i].b;
        in_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        exp_c = '0;
        exp_v = 1'b0;
        check_c("midrst_async", 5'b0);
        check_v("midrst_async", 1'b0);
        @(posedge clk);
        #1;
        check_c("midrst_discard", 5'b0);
        check_v("midrst_discard", 1'b0);
        $display("midrst: C=%b ov=%b", C, out_valid);
        #2 rst = 1'b0;
      end else begin
        step(tbl[i].a, tbl[i].b, 1'b1, "stream");
      end
    end
    step(tbl[6].a, tbl[6].b, 1'b1, "after_midrst");
    check_c("after_midrst_const", 5'b10000);

    // Exhaustive sweep against the package reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(4'(a), 4'(b), 1'b1, "sweep");
        r = sum_com_ref(32'(a), 32'(b));
        check_c("sweep_ref", r[4:0]);
      end
    end

    // Random traffic with random valid gaps.
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
